// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and slot-decode helpers for the
// six-digit multiplexed seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         NUM_DIGITS = 6;
    localparam logic [5:0] ANODES_OFF = 6'h3F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

    typedef logic [2:0] slot_t;

    function automatic logic [5:0] anode_mask(input slot_t slot);
        case (slot)
            3'd0:    anode_mask = 6'b111110;
            3'd1:    anode_mask = 6'b111101;
            3'd2:    anode_mask = 6'b111011;
            3'd3:    anode_mask = 6'b110111;
            3'd4:    anode_mask = 6'b101111;
            3'd5:    anode_mask = 6'b011111;
            default: anode_mask = ANODES_OFF;
        endcase
    endfunction

    // Snapshot layout is {digits_2, digits_1, digits_0}, low digit first.
    function automatic logic [6:0] slot_pattern(input logic [41:0] snap, input slot_t slot);
        case (slot)
            3'd0:    slot_pattern = snap[6:0];
            3'd1:    slot_pattern = snap[13:7];
            3'd2:    slot_pattern = snap[20:14];
            3'd3:    slot_pattern = snap[27:21];
            3'd4:    slot_pattern = snap[34:28];
            3'd5:    slot_pattern = snap[41:35];
            default: slot_pattern = SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bundle of digit inputs and display outputs of the scan driver.
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [13:0] digits_0;
    logic [13:0] digits_1;
    logic [13:0] digits_2;
    logic        overload;
    logic [6:0]  segments;
    logic        dp;
    logic [5:0]  anodes;
    logic        frame_start;

    modport master (
        output digits_0, digits_1, digits_2, overload,
        input  segments, dp, anodes, frame_start
    );

    modport slave (
        input  digits_0, digits_1, digits_2, overload,
        output segments, dp, anodes, frame_start
    );

endinterface

// File: rtl/seg7_scan_driver_tick.sv
// Free-running slot-position counter; tick marks the last cycle of a slot.
module tick_divider #(
    parameter int CLK_DIV = 50000,
    parameter int COUNT_W = $clog2(CLK_DIV)
) (
    input  logic               clock,
    input  logic               reset,
    output logic [COUNT_W-1:0] count,
    output logic               tick
);

    assign tick = (count == COUNT_W'(CLK_DIV - 1));

    // Position within the current slot, wrapping at CLK_DIV.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= {COUNT_W{1'b0}};
        end else if (tick) begin
            count <= {COUNT_W{1'b0}};
        end else begin
            count <= count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-slot multiplexed seven-segment scanner with per-frame input snapshot,
// leading blanking in every slot and overload blink on the answer digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus
);

    localparam int COUNT_W = $clog2(CLK_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [COUNT_W-1:0] pos_s;
    logic               slot_end_s;
    logic               frame_edge_s;
    logic [6:0]         drive_seg_s;
    logic               drive_dp_s;

    slot_t              slot_r;
    scan_state_t        state_r;
    logic [41:0]        snap_digits_r;
    logic               snap_ovl_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_on_r;
    logic [6:0]         segments_r;
    logic               dp_r;
    logic [5:0]         anodes_r;
    logic               frame_start_r;

    tick_divider #(
        .CLK_DIV (CLK_DIV),
        .COUNT_W (COUNT_W)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .count (pos_s),
        .tick  (slot_end_s)
    );

    // pos_s/slot_r describe the cycle being loaded into the output registers.
    assign frame_edge_s = (pos_s == {COUNT_W{1'b0}}) && (slot_r == 3'd0);

    // Slot index advances on the last cycle of each slot.
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_r <= 3'd0;
        end else if (slot_end_s) begin
            slot_r <= (slot_r == 3'(NUM_DIGITS - 1)) ? 3'd0 : slot_r + 3'd1;
        end else begin
            slot_r <= slot_r;
        end
    end

    // Frame snapshot and blink phase; the first overloaded frame starts in the on phase.
    always_ff @(posedge clock) begin
        if (!reset) begin
            snap_digits_r <= {42{1'b1}};
            snap_ovl_r    <= 1'b0;
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_on_r    <= 1'b1;
        end else if (frame_edge_s) begin
            snap_digits_r <= {bus.digits_2, bus.digits_1, bus.digits_0};
            snap_ovl_r    <= bus.overload;
            if (!bus.overload) begin
                blink_cnt_r <= {BLINK_W{1'b0}};
                blink_on_r  <= 1'b1;
            end else if (snap_ovl_r) begin
                if (blink_cnt_r == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt_r <= {BLINK_W{1'b0}};
                    blink_on_r  <= ~blink_on_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
                    blink_on_r  <= blink_on_r;
                end
            end else begin
                blink_cnt_r <= blink_cnt_r;
                blink_on_r  <= blink_on_r;
            end
        end else begin
            snap_digits_r <= snap_digits_r;
            snap_ovl_r    <= snap_ovl_r;
            blink_cnt_r   <= blink_cnt_r;
            blink_on_r    <= blink_on_r;
        end
    end

    // DRIVE-state segment and decimal-point values for the current slot.
    always_comb begin
        drive_seg_s = slot_pattern(snap_digits_r, slot_r);
        drive_dp_s  = 1'b1;
        if (snap_ovl_r && !blink_on_r && (slot_r >= 3'd4)) begin
            drive_seg_s = SEG_OFF;
        end else begin
            drive_seg_s = slot_pattern(snap_digits_r, slot_r);
        end
        if (snap_ovl_r && (slot_r == 3'd5)) begin
            drive_dp_s = 1'b0;
        end else begin
            drive_dp_s = 1'b1;
        end
    end

    // BLANK/DRIVE FSM with registered display outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_BLANK;
            segments_r    <= SEG_OFF;
            dp_r          <= 1'b1;
            anodes_r      <= ANODES_OFF;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_edge_s;
            case (state_r)
                ST_BLANK: begin
                    if (pos_s == COUNT_W'(BLANK_CYCLES)) begin
                        state_r    <= ST_DRIVE;
                        segments_r <= drive_seg_s;
                        dp_r       <= drive_dp_s;
                        anodes_r   <= anode_mask(slot_r);
                    end else begin
                        state_r    <= ST_BLANK;
                        segments_r <= SEG_OFF;
                        dp_r       <= 1'b1;
                        anodes_r   <= ANODES_OFF;
                    end
                end
                ST_DRIVE: begin
                    if (pos_s == {COUNT_W{1'b0}}) begin
                        state_r    <= ST_BLANK;
                        segments_r <= SEG_OFF;
                        dp_r       <= 1'b1;
                        anodes_r   <= ANODES_OFF;
                    end else begin
                        state_r    <= ST_DRIVE;
                        segments_r <= drive_seg_s;
                        dp_r       <= drive_dp_s;
                        anodes_r   <= anode_mask(slot_r);
                    end
                end
                default: begin
                    state_r    <= ST_BLANK;
                    segments_r <= SEG_OFF;
                    dp_r       <= 1'b1;
                    anodes_r   <= ANODES_OFF;
                end
            endcase
        end
    end

    assign bus.segments    = segments_r;
    assign bus.dp          = dp_r;
    assign bus.anodes      = anodes_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver against a time-indexed display model.
module tb_seg7_scan_driver;

    localparam int CD    = 4;
    localparam int BC    = 1;
    localparam int BF    = 2;
    localparam int FRAME = 6 * CD;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .CLK_DIV      (CD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          t;
    logic [41:0] m_snap;
    logic        m_ovl;
    int          m_k;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic reset_check();
        @(posedge clock);
        #1;
        check_val("rst_anodes", 32'(bus.anodes), 32'h3F);
        check_val("rst_segments", 32'(bus.segments), 32'h7F);
        check_val("rst_dp", 32'(bus.dp), 32'h1);
        check_val("rst_frame_start", 32'(bus.frame_start), 32'h0);
    endtask

    // One output cycle t after reset release; the model is indexed by elapsed time only.
    task automatic cycle_check();
        int          slot;
        int          pos;
        logic [5:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        blink_off;
        @(posedge clock);
        #1;
        slot = (t % FRAME) / CD;
        pos  = t % CD;
        if (t % FRAME == 0) begin
            m_snap = {bus.digits_2, bus.digits_1, bus.digits_0};
            m_ovl  = bus.overload;
            m_k    = m_ovl ? m_k + 1 : 0;
        end
        blink_off = m_ovl && ((((m_k - 1) / BF) % 2) == 1);
        e_an  = 6'h3F;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (pos >= BC) begin
            e_an[slot] = 1'b0;
            e_seg = m_snap[slot*7 +: 7];
            if (blink_off && slot >= 4) e_seg = 7'h7F;
            if (m_ovl && slot == 5) e_dp = 1'b0;
        end
        check_val("anodes", 32'(bus.anodes), 32'(e_an));
        check_val("segments", 32'(bus.segments), 32'(e_seg));
        check_val("dp", 32'(bus.dp), 32'(e_dp));
        check_val("frame_start", 32'(bus.frame_start), (t % FRAME == 0) ? 32'h1 : 32'h0);
        check_val("one_anode", ($countones(~bus.anodes) <= 1) ? 32'h1 : 32'h0, 32'h1);
        t++;
    endtask

    initial begin
        bus.digits_0 = 14'h0001;
        bus.digits_1 = 14'h0002;
        bus.digits_2 = 14'h0004;
        bus.overload = 1'b0;
        t     = 0;
        m_k   = 0;
        m_ovl = 1'b0;
        m_snap = {42{1'b1}};
        repeat (3) reset_check();

        // Static scan over two frames.
        reset = 1'b1;
        repeat (2 * FRAME) cycle_check();

        // Tearing: new digits_0 in the middle of slot 2.
        while (t % FRAME != 10) cycle_check();
        bus.digits_0 = 14'h1ABC;
        repeat (2 * FRAME) cycle_check();

        // Overload blink with a zero answer.
        bus.digits_2 = 14'h0000;
        bus.overload = 1'b1;
        repeat (8 * FRAME) cycle_check();
        bus.overload = 1'b0;
        repeat (2 * FRAME) cycle_check();

        // Reset during slot 3 DRIVE while overloaded.
        bus.overload = 1'b1;
        while (t % FRAME != 14) cycle_check();
        reset = 1'b0;
        reset_check();
        reset = 1'b1;
        t   = 0;
        m_k = 0;
        repeat (6 * FRAME) cycle_check();

        // Random digits and overload toggling.
        repeat (60 * FRAME) begin
            cycle_check();
            case ($urandom_range(0, 29))
                0:       bus.digits_0 = 14'($urandom);
                1:       bus.digits_1 = 14'($urandom);
                2:       bus.digits_2 = 14'($urandom);
                3:       bus.overload = ~bus.overload;
                default: ;
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clock cycles per digit slot, minimum 4.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, leading inactive cycles per slot, range 1 to CLK_DIV-2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, frames per overload blink half-period, minimum 1.
REQ-004 SHALL have port: clock  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-low.
REQ-006 SHALL have port: digits_0  in  14  operand-0 segment pair; [6:0] low digit, [13:7] high digit, active-low segments.
REQ-007 SHALL have port: digits_1  in  14  operand-1 segment pair; same layout.
REQ-008 SHALL have port: digits_2  in  14  answer segment pair; same layout.
REQ-009 SHALL have port: overload  in  1  answer carry-out flag.
REQ-010 SHALL have port: segments  out  7  shared segment bus, active-low.
REQ-011 SHALL have port: dp  out  1  decimal point, active-low.
REQ-012 SHALL have port: anodes  out  6  digit enables, active-low, one-hot-or-none.
REQ-013 SHALL have port: frame_start  out  1  one-cycle pulse at start of slot 0.

Function
REQ-014 SHALL scan slots 0..5 in order, wrapping 5->0: slot0=digits_0[6:0], slot1=digits_0[13:7], slot2=digits_1[6:0], slot3=digits_1[13:7], slot4=digits_2[6:0], slot5=digits_2[13:7].
REQ-015 SHALL last exactly CLK_DIV cycles per slot; frame = 6*CLK_DIV cycles.
REQ-016 SHALL run two-state FSM per slot: BLANK (first BLANK_CYCLES cycles: anodes=6'b111111, segments=7'h7F, dp=1) -> DRIVE (remaining cycles: anodes[slot]=0, others 1) -> BLANK of next slot.
REQ-017 SHALL snapshot all 42 digit bits and overload in the cycle frame_start is asserted; outputs use only the snapshot for the whole frame; mid-frame input changes have no effect until the next frame.
REQ-018 SHALL register all outputs; the DRIVE-state segment value equals the snapshot pattern for the current slot unchanged.
REQ-019 SHALL, while snapshot overload=1, count frames; the blink phase toggles every BLINK_FRAMES frames; during the off phase, slots 4 and 5 in DRIVE output segments=7'h7F with the anode still asserted.
REQ-020 SHALL, while snapshot overload=1, drive dp=0 in slot 5 DRIVE regardless of blink phase; dp=1 in all other cases.
REQ-021 SHALL, when overload returns to 0, clear the blink counter and set the phase to on at that frame snapshot.
REQ-022 SHALL never assert two anodes simultaneously, including on slot wrap and reset release.
REQ-023 SHALL pulse frame_start for exactly one cycle every 6*CLK_DIV cycles, first pulse one cycle after reset release.

Reset
REQ-024 SHALL, with reset=0 at a rising edge, set anodes=6'b111111, segments=7'h7F, dp=1, frame_start=0, slot=0, cycle counter=0, FSM=BLANK, blink counter=0, phase=on, snapshot=all-off with overload=0.
REQ-025 SHALL abort any slot in progress when reset is asserted mid-frame; no partial-slot output after release.

Structure
REQ-026 SHALL place SEG_OFF (7'h7F), NUM_DIGITS (6), and the BLANK/DRIVE state encoding in shared package seg7_pkg.
REQ-027 SHALL use one sub-module, tick_divider, producing the slot-boundary strobe from CLK_DIV.

Verification
All scenarios use CLK_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2.
REQ-028 SHALL cover static scan: digits_0=14'h0001, digits_1=14'h0002, digits_2=14'h0004, overload=0 -> anodes cycle 111110..011111 with 3 DRIVE cycles each and segments 01,00,02,00,04,00 per slot; frame_start period is 24 cycles.
REQ-029 SHALL cover blanking: every slot boundary shows exactly 1 cycle of anodes=111111 and segments=7F; no cycle has more than one anode low.
REQ-030 SHALL cover tearing: change digits_0 mid-slot 2 -> slots 0/1 update only in the next frame.
REQ-031 SHALL cover overload blink: overload=1, digits_2=14'h0000 -> slots 4/5 segments alternate 00 for 2 frames then 7F for 2 frames; dp=0 in slot 5 DRIVE every frame.
REQ-032 SHALL cover reset mid-frame: reset=0 during slot 3 DRIVE -> next cycle has all outputs at reset values; after release, frame_start fires after 1 cycle and scanning resumes at slot 0.
